// File: rtl/divider_seq.sv
// Sequential 32-bit restoring divider (DIV/DIVU) producing one quotient bit per cycle.
// Results are sign-corrected and held until the next completion; divide-by-zero bypasses iteration.
module divider_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sign,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] q,
  output logic [31:0] r,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_dvd;
  logic [W-1:0]    r_dvs;
  logic [W-1:0]    r_rem;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [W-1:0]    r_q;
  logic [W-1:0]    r_r;
  logic            r_busy;
  logic            r_done;
  logic            r_div_zero;

  logic [W-1:0]    w_a_mag;
  logic [W-1:0]    w_b_mag;
  logic            w_b_zero;
  logic            w_last;
  logic [W:0]      w_rem_sh;
  logic            w_qbit;
  logic [W-1:0]    w_rem_nxt;
  logic [W-1:0]    w_q_mag;
  logic [W-1:0]    w_q_fix;
  logic [W-1:0]    w_r_fix;

  assign w_a_mag  = (sign && dividend[W-1]) ? (~dividend + W'(1)) : dividend;
  assign w_b_mag  = (sign && divisor[W-1])  ? (~divisor + W'(1))  : divisor;
  assign w_b_zero = (divisor == '0);
  assign w_last   = (r_cnt == CW'(W - 1));

  // One restoring step: the 33-bit shifted partial remainder keeps the borrow visible.
  assign w_rem_sh  = {r_rem, r_dvd[W-1]};
  assign w_qbit    = (w_rem_sh >= {1'b0, r_dvs});
  assign w_rem_nxt = w_qbit ? W'(w_rem_sh - {1'b0, r_dvs}) : w_rem_sh[W-1:0];
  assign w_q_mag   = {r_dvd[W-2:0], w_qbit};
  assign w_q_fix   = r_neg_q ? (~w_q_mag + W'(1)) : w_q_mag;
  assign w_r_fix   = r_neg_r ? (~w_rem_nxt + W'(1)) : w_rem_nxt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = w_b_zero ? DONE : CALC;
      CALC:    if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_rem      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_q        <= '0;
      r_r        <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == CALC);
      r_done  <= (w_state_nxt == DONE);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_dvd   <= w_a_mag;
            r_dvs   <= w_b_mag;
            r_neg_q <= sign && (dividend[W-1] ^ divisor[W-1]);
            r_neg_r <= sign && dividend[W-1];
            if (w_b_zero) begin
              r_q        <= '1;
              r_r        <= dividend;
              r_div_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          r_cnt <= r_cnt + CW'(1);
          r_rem <= w_rem_nxt;
          r_dvd <= w_q_mag;
          if (w_last) begin
            r_q        <= w_q_fix;
            r_r        <= w_r_fix;
            r_div_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign q        = r_q;
  assign r        = r_r;
  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;

endmodule

// File: doc/divider_seq.md
DIVIDER_SEQ -- requirements
Module: divider_seq

Interface
REQ-001 The block SHALL have no parameters; operand width SHALL be fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 sign  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
REQ-006 dividend  input  32  operand A, driven from register-file read port 1.
REQ-007 divisor  input  32  operand B, driven from register-file read port 2.
REQ-008 q  output  32  quotient, registered; feeds LO or the write-back mux.
REQ-009 r  output  32  remainder, registered; feeds HI.
REQ-010 busy  output  1  high while an iteration sequence is running.
REQ-011 done  output  1  single-cycle pulse; q and r are valid and final.
REQ-012 div_zero  output  1  registered flag; last completed operation had divisor == 0.

Function
REQ-013 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-014 IDLE with start=1 at edge E0 SHALL capture sign, the operand magnitudes and the result signs.
- Magnitudes are the two's-complement absolute values when sign=1, raw values when sign=0.
- At E0 the iteration counter SHALL load 0 and the FSM SHALL go to CALC.
REQ-015 In CALC the block SHALL perform one restoring shift-subtract step per edge, producing one quotient bit MSB-first.
- The partial remainder SHALL be 33 bits wide so the subtraction borrow is never lost.
REQ-016 At the 32nd CALC edge (E32, counter == 31) the block SHALL do the following:
- Register q and r with sign correction applied.
- q SHALL be negated when sign=1 and the operand signs differ.
- r SHALL be negated when sign=1 and the dividend is negative.
- The FSM SHALL go to DONE.
REQ-017 done SHALL be 1 exactly while in DONE (the cycle after E32); the FSM SHALL return to IDLE at the next edge.
REQ-018 busy SHALL be 1 exactly while in CALC.
REQ-019 start SHALL be ignored in CALC and DONE; no operand capture occurs in those states.
REQ-020 A divisor of 0 at E0 SHALL skip CALC: the FSM SHALL go directly to DONE with q=32'hFFFFFFFF, r=dividend (unmodified) and div_zero=1.
REQ-021 div_zero SHALL be cleared on every other completion.
REQ-022 Signed 0x80000000 / 0xFFFFFFFF SHALL produce q=0x80000000, r=0, with no trap and no flag.
REQ-023 q, r and div_zero SHALL hold their values from one completion until the next completion or reset.
REQ-024 Operand inputs SHALL be don't-care after E0; a register-file write during CALC SHALL NOT affect the result.

Reset
REQ-025 rst=1 SHALL immediately force the following, regardless of clk:
- state=IDLE, counter=0, q=0, r=0, busy=0, done=0, div_zero=0.
REQ-026 rst asserted mid-CALC SHALL abort the operation with no done pulse.
- The first edge with rst=0 and start=1 SHALL begin a fresh operation.

Verification
REQ-027 DIVU 100 / 7 -> busy high for 32 cycles; done pulses in the cycle after E32; q=14, r=2, div_zero=0.
REQ-028 DIV 0xFFFFFFF9 (-7) / 2 -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1).
REQ-029 DIV 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0; DIVU 0xFFFFFFFF / 1 -> q=0xFFFFFFFF, r=0.
REQ-030 DIVU 1234 / 0 -> no busy; done in the cycle after E0; q=0xFFFFFFFF, r=1234, div_zero=1. A following DIVU 9 / 3 -> q=3, r=0, div_zero=0.
REQ-031 start toggled with new operands during CALC -> ignored; the original result is delivered at E32.
REQ-032 rst pulsed at CALC cycle 10 -> busy=0 and q=r=0 immediately; no done; a subsequent DIVU 50 / 5 -> q=10, r=0.
